// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, ALU opcode bit positions and the decoded
// ID->EX bundle layout for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 141;
    localparam int EX_TO_RF_WD  = 38;
    localparam int DIV_CYCLES   = 32;
    localparam int STALL_WD     = 6;

    typedef logic [STALL_WD-1:0] stall_bus_t;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op is one-hot, add in the MSB
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_bundle_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-side bus of the execute stage: decode input, stall vector,
// MEM/forwarding outputs and the data-SRAM request.
interface ex_stage_if;
    import ex_stage_pkg::*;

    stall_bus_t                stall;
    logic [ID_TO_EX_WD-1:0]    id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0]   ex_to_mem_bus;
    logic [EX_TO_RF_WD-1:0]    ex_to_rf_bus;
    logic                      data_sram_en;
    logic [3:0]                data_sram_wen;
    logic [31:0]               data_sram_addr;
    logic [31:0]               data_sram_wdata;
    logic                      stallreq_for_ex;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign-corrected result presented for one DONE cycle.
module ex_stage_div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    div_state_t  state;
    logic [5:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] b_mag;
    logic        q_neg;
    logic        r_neg;
    logic        b_zero;

    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [32:0] trial;
    logic        take;

    assign a_mag_in = (signed_en && a[31]) ? (32'd0 - a) : a;
    assign b_mag_in = (signed_en && b[31]) ? (32'd0 - b) : b;
    assign trial    = {rem, quo[31]};
    assign take     = trial >= {1'b0, b_mag};

    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DIV_IDLE;
            count  <= '0;
            quo    <= '0;
            rem    <= '0;
            b_mag  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state  <= DIV_BUSY;
                        count  <= 6'(DIV_CYCLES);
                        quo    <= a_mag_in;
                        rem    <= '0;
                        b_mag  <= b_mag_in;
                        q_neg  <= signed_en && (a[31] ^ b[31]);
                        r_neg  <= signed_en && a[31];
                        b_zero <= (b == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    // quo doubles as the dividend shift register; quotient bits enter at the LSB
                    rem   <= take ? (trial[31:0] - b_mag) : trial[31:0];
                    quo   <= {quo[30:0], take};
                    count <= count - 6'd1;
                    if (count == 6'd1) state <= DIV_DONE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign q    = b_zero ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quo) : quo);
    assign r    = r_neg ? (32'd0 - rem) : rem;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: pipe register, one-hot ALU, SRAM request, mult and
// iterative div. Define EX_MULT_EN to build the mult/multu multiplier.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    id_bundle_t  pipe_q;
    logic        done_flag;
    logic        bubble;
    logic        load;

    assign bubble = (bus.stall[2] == STOP) && (bus.stall[3] == NO_STOP);
    assign load   = (bus.stall[2] == NO_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pipe_q <= '0;
        else if (bubble) pipe_q <= '0;
        else if (load)   pipe_q <= bus.id_to_ex_bus;
    end

    logic        md_form;
    logic [5:0]  func;
    logic        is_div;
    logic        is_divu;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign func      = pipe_q.inst[5:0];
    assign md_form   = (pipe_q.inst[31:26] == 6'd0) && (pipe_q.inst[15:11] == 5'd0)
                       && (pipe_q.inst[10:6] == 5'd0);
    assign is_div    = md_form && (func == FUNC_DIV);
    assign is_divu   = md_form && (func == FUNC_DIVU);
    assign div_start = (is_div || is_divu) && !done_flag;

    // A finished divide held by a downstream stall must not restart; any pipe load re-arms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 done_flag <= 1'b0;
        else if (bubble || load)  done_flag <= 1'b0;
        else if (div_done)        done_flag <= 1'b1;
    end

    ex_stage_div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_en (is_div),
        .a         (pipe_q.rdata1),
        .b         (pipe_q.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_res;

    assign src1 = ({32{pipe_q.sel_src1[0]}} & pipe_q.rdata1)
                | ({32{pipe_q.sel_src1[1]}} & pipe_q.pc)
                | ({32{pipe_q.sel_src1[2]}} & {27'd0, pipe_q.inst[10:6]});
    assign src2 = ({32{pipe_q.sel_src2[0]}} & pipe_q.rdata2)
                | ({32{pipe_q.sel_src2[1]}} & {{16{pipe_q.inst[15]}}, pipe_q.inst[15:0]})
                | ({32{pipe_q.sel_src2[2]}} & 32'd8)
                | ({32{pipe_q.sel_src2[3]}} & {16'd0, pipe_q.inst[15:0]});

    // NOTE: default assignment first so no path leaves alu_res unassigned (no latch).
    always_comb begin
        alu_res = '0;
        if (pipe_q.alu_op[OP_ADD])  alu_res |= src1 + src2;
        if (pipe_q.alu_op[OP_SUB])  alu_res |= src1 - src2;
        if (pipe_q.alu_op[OP_SLT])  alu_res |= {31'd0, $signed(src1) < $signed(src2)};
        if (pipe_q.alu_op[OP_SLTU]) alu_res |= {31'd0, src1 < src2};
        if (pipe_q.alu_op[OP_AND])  alu_res |= src1 & src2;
        if (pipe_q.alu_op[OP_NOR])  alu_res |= ~(src1 | src2);
        if (pipe_q.alu_op[OP_OR])   alu_res |= src1 | src2;
        if (pipe_q.alu_op[OP_XOR])  alu_res |= src1 ^ src2;
        if (pipe_q.alu_op[OP_SLL])  alu_res |= src2 << src1[4:0];
        if (pipe_q.alu_op[OP_SRL])  alu_res |= src2 >> src1[4:0];
        if (pipe_q.alu_op[OP_SRA])  alu_res |= $unsigned($signed(src2) >>> src1[4:0]);
        if (pipe_q.alu_op[OP_LUI])  alu_res |= {src2[15:0], 16'd0};
    end

    logic        mult_we;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

`ifdef EX_MULT_EN
    logic        is_mult;
    logic        is_multu;
    logic [63:0] mult_a;
    logic [63:0] mult_b;
    logic [63:0] prod;

    assign is_mult  = md_form && (func == FUNC_MULT);
    assign is_multu = md_form && (func == FUNC_MULTU);
    // One 64x64 multiplier: sign-extending for mult makes the low 64 bits the signed product
    assign mult_a   = {{32{is_mult & pipe_q.rdata1[31]}}, pipe_q.rdata1};
    assign mult_b   = {{32{is_mult & pipe_q.rdata2[31]}}, pipe_q.rdata2};
    assign prod     = mult_a * mult_b;
    assign mult_we  = is_mult || is_multu;
    assign mult_hi  = mult_we ? prod[63:32] : 32'd0;
    assign mult_lo  = mult_we ? prod[31:0]  : 32'd0;
`else
    assign mult_we  = 1'b0;
    assign mult_hi  = 32'd0;
    assign mult_lo  = 32'd0;
`endif

    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    assign hilo_we = mult_we || div_done;
    assign hi      = div_done ? div_r : mult_hi;
    assign lo      = div_done ? div_q : mult_lo;

    assign bus.ex_to_mem_bus   = {pipe_q.pc, pipe_q.ram_en, pipe_q.ram_wen, pipe_q.sel_rf_res,
                                  pipe_q.rf_we, pipe_q.rf_waddr, alu_res, hilo_we, hi, lo};
    assign bus.ex_to_rf_bus    = {pipe_q.rf_we, pipe_q.rf_waddr, alu_res};
    assign bus.data_sram_en    = pipe_q.ram_en;
    assign bus.data_sram_wen   = pipe_q.ram_wen;
    assign bus.data_sram_addr  = alu_res;
    assign bus.data_sram_wdata = pipe_q.rdata2;
    assign bus.stallreq_for_ex = div_busy;

    // rs/rt reach the datapath as rdata1/rdata2; other stall bits belong to other stages
    logic unused_fields;
    assign unused_fields = ^{pipe_q.inst[25:16], bus.stall[5:4], bus.stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; a stand-in stall controller
// freezes stages 0-3 whenever the divider requests a stall.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    stall_bus_t stall_drv;
    int         errors = 0;
    int         checks = 0;
    int         n;

    always #5 clk = ~clk;

    ex_stage_if bus ();
    assign bus.stall = bus.stallreq_for_ex ? 6'b001111 : stall_drv;

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] op(input int idx);
        logic [11:0] one;
        one = 12'd1;
        return one << idx;
    endfunction

    function automatic id_bundle_t mk(input logic [31:0] inst, input logic [11:0] alu_op,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ram_en, input logic [3:0] wen,
                                      input logic rf_we, input logic [4:0] waddr,
                                      input logic [31:0] r1, input logic [31:0] r2);
        id_bundle_t b;
        b.pc = 32'hBFC0_0100;  b.inst = inst;     b.alu_op = alu_op;
        b.sel_src1 = s1;       b.sel_src2 = s2;   b.ram_en = ram_en;
        b.ram_wen = wen;       b.rf_we = rf_we;   b.rf_waddr = waddr;
        b.sel_rf_res = 1'b0;   b.rdata1 = r1;     b.rdata2 = r2;
        return b;
    endfunction

    // MEM bus fields: lo[31:0] hi[63:32] hilo_we[64] result[96:65]
    function automatic logic [31:0] mem_lo();  return bus.ex_to_mem_bus[31:0];  endfunction
    function automatic logic [31:0] mem_hi();  return bus.ex_to_mem_bus[63:32]; endfunction
    function automatic logic        mem_we();  return bus.ex_to_mem_bus[64];    endfunction
    function automatic logic [31:0] mem_res(); return bus.ex_to_mem_bus[96:65]; endfunction

    // Issues one div/divu and leaves the bench sampling the DONE cycle.
    task automatic run_div(input string tag, input logic [5:0] func, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        bus.id_to_ex_bus = mk({6'd0, 5'd1, 5'd2, 10'd0, func}, 12'd0, 3'b000, 4'b0000,
                              1'b0, 4'h0, 1'b0, 5'd0, a, b);
        step();
        bus.id_to_ex_bus = '0;
        n = 0;
        while (bus.stallreq_for_ex && n < 100) begin
            n++;
            step();
        end
        check({tag, "_stall_cycles"}, 160'(n), 160'(33));
        check({tag, "_lo"}, 160'(mem_lo()), 160'(exp_lo));
        check({tag, "_hi"}, 160'(mem_hi()), 160'(exp_hi));
        check({tag, "_hilo_we"}, 160'(mem_we()), 160'(1'b1));
    endtask

    initial begin
        rst = 1'b0;
        stall_drv = '0;
        bus.id_to_ex_bus = '0;
        step();
        check("rst_mem_bus", 160'(bus.ex_to_mem_bus), 160'd0);
        check("rst_rf_bus", 160'(bus.ex_to_rf_bus), 160'd0);
        check("rst_sram", 160'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                                bus.data_sram_wdata}), 160'd0);
        check("rst_stallreq", 160'(bus.stallreq_for_ex), 160'd0);
        rst = 1'b1;

        // addiu $3, $1, -1 with $1=5
        bus.id_to_ex_bus = mk({6'h09, 5'd1, 5'd3, 16'hFFFF}, op(OP_ADD), 3'b001, 4'b0010,
                              1'b0, 4'h0, 1'b1, 5'd3, 32'd5, 32'd0);
        step();
        check("addiu_rf_bus", 160'(bus.ex_to_rf_bus), 160'({1'b1, 5'd3, 32'd4}));
        check("addiu_hilo_we", 160'(mem_we()), 160'd0);
        check("addiu_sram_en", 160'(bus.data_sram_en), 160'd0);

        // sw $2, 8($1)
        bus.id_to_ex_bus = mk({6'h2B, 5'd1, 5'd2, 16'd8}, op(OP_ADD), 3'b001, 4'b0010,
                              1'b1, 4'hF, 1'b0, 5'd0, 32'h0000_1000, 32'hDEAD_BEEF);
        step();
        check("sw_en", 160'(bus.data_sram_en), 160'd1);
        check("sw_wen", 160'(bus.data_sram_wen), 160'hF);
        check("sw_addr", 160'(bus.data_sram_addr), 160'h1008);
        check("sw_wdata", 160'(bus.data_sram_wdata), 160'hDEAD_BEEF);

        bus.id_to_ex_bus = mk(32'd0, op(OP_SLT), 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                              32'hFFFF_FFFF, 32'd1);
        step();
        check("slt_signed", 160'(mem_res()), 160'd1);

        bus.id_to_ex_bus = mk(32'd0, op(OP_SLTU), 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                              32'hFFFF_FFFF, 32'd1);
        step();
        check("sltu_unsigned", 160'(mem_res()), 160'd0);

        bus.id_to_ex_bus = mk(32'd0, op(OP_SUB), 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                              32'd0, 32'd1);
        step();
        check("sub_wrap", 160'(mem_res()), 160'hFFFF_FFFF);

        // sra $4, $2, 4
        bus.id_to_ex_bus = mk({6'd0, 5'd0, 5'd2, 5'd4, 5'd4, 6'h03}, op(OP_SRA), 3'b100, 4'b0001,
                              1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'h8000_0000);
        step();
        check("sra_arith", 160'(mem_res()), 160'hF800_0000);

        bus.id_to_ex_bus = mk({6'h0F, 5'd0, 5'd4, 16'h1234}, op(OP_LUI), 3'b000, 4'b1000,
                              1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0);
        step();
        check("lui", 160'(mem_res()), 160'h1234_0000);

        bus.id_to_ex_bus = mk(32'd0, op(OP_ADD), 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31,
                              32'd0, 32'd0);
        step();
        check("pc_plus_8", 160'(mem_res()), 160'hBFC0_0108);

        bus.id_to_ex_bus = mk(32'd0, op(OP_NOR), 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                              32'h0F0F_0000, 32'h0000_00FF);
        step();
        check("nor", 160'(mem_res()), 160'hF0F0_FF00);

        bus.id_to_ex_bus = mk(32'd0, 12'd0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                              32'h1234_5678, 32'h1);
        step();
        check("no_op_zero", 160'(mem_res()), 160'd0);

        run_div("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        step();
        check("after_div_hilo_we", 160'(mem_we()), 160'd0);
        check("after_div_stallreq", 160'(bus.stallreq_for_ex), 160'd0);

        run_div("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        step();

        run_div("divu_9_0", 6'h1B, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
        stall_drv = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_div_no_rerun", 160'(bus.stallreq_for_ex), 160'd0);
        end
        check("held_div_hilo_we", 160'(mem_we()), 160'd0);
        stall_drv = '0;
        step();

        // Bubble: stage stopped, MEM running
        bus.id_to_ex_bus = mk({6'h09, 5'd1, 5'd3, 16'hFFFF}, op(OP_ADD), 3'b001, 4'b0010,
                              1'b0, 4'h0, 1'b1, 5'd3, 32'd5, 32'd0);
        step();
        stall_drv = 6'b000100;
        step();
        check("bubble_mem_bus", 160'(bus.ex_to_mem_bus), 160'd0);
        check("bubble_rf_bus", 160'(bus.ex_to_rf_bus), 160'd0);
        stall_drv = '0;

        // Reset pulse in the middle of a divide
        bus.id_to_ex_bus = mk({6'd0, 5'd1, 5'd2, 10'd0, 6'h1A}, 12'd0, 3'b000, 4'b0000,
                              1'b0, 4'h0, 1'b0, 5'd0, 32'd100, 32'd7);
        step();
        bus.id_to_ex_bus = '0;
        repeat (5) step();
        check("busy_stallreq", 160'(bus.stallreq_for_ex), 160'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_div_stallreq", 160'(bus.stallreq_for_ex), 160'd0);
        check("rst_mid_div_mem_bus", 160'(bus.ex_to_mem_bus), 160'd0);
        check("rst_mid_div_sram", 160'({bus.data_sram_en, bus.data_sram_addr,
                                        bus.data_sram_wdata}), 160'd0);
        #2;
        rst = 1'b1;
        step();
        check("post_rst_stallreq", 160'(bus.stallreq_for_ex), 160'd0);

        // multu 0xFFFFFFFF x 2, then mult -3 x 4
        bus.id_to_ex_bus = mk({6'd0, 5'd1, 5'd2, 10'd0, 6'h19}, 12'd0, 3'b000, 4'b0000,
                              1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd2);
        step();
`ifdef EX_MULT_EN
        check("multu_hi", 160'(mem_hi()), 160'd1);
        check("multu_lo", 160'(mem_lo()), 160'hFFFF_FFFE);
        check("multu_hilo_we", 160'(mem_we()), 160'd1);
`else
        check("multu_off_hilo_we", 160'(mem_we()), 160'd0);
        check("multu_off_hilo", 160'({mem_hi(), mem_lo()}), 160'd0);
`endif
        bus.id_to_ex_bus = mk({6'd0, 5'd1, 5'd2, 10'd0, 6'h18}, 12'd0, 3'b000, 4'b0000,
                              1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFFD, 32'd4);
        step();
`ifdef EX_MULT_EN
        check("mult_signed", 160'({mem_hi(), mem_lo()}), 160'h FFFF_FFFF_FFFF_FFF4);
`else
        check("mult_off_hilo_we", 160'(mem_we()), 160'd0);
`endif
        check("mult_stallreq", 160'(bus.stallreq_for_ex), 160'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
